// File: rtl/seg_scan.sv
// Six-digit multiplexed 7-segment driver: per-frame input shadowing, digit scan,
// free-running blink and registered segment/enable outputs.
module seg_scan #(
    parameter int unsigned SCAN_DIV  = 1000,
    parameter int unsigned BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [23:0] i_six_bcd,
    input  logic [5:0]  i_six_dp,
    input  logic [5:0]  i_blink_mask,
    output logic [5:0]  o_seg_enb,
    output logic [6:0]  o_seg,
    output logic        o_seg_dp
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned NDIG    = 6;

    logic [SCAN_W-1:0]  scan_cnt_q,    scan_cnt_d;
    logic [IDX_W-1:0]   idx_q,         idx_d;
    logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [23:0]        shadow_bcd_q,  shadow_bcd_d;
    logic [NDIG-1:0]    shadow_dp_q,   shadow_dp_d;
    logic [NDIG-1:0]    shadow_mask_q, shadow_mask_d;
    logic               load_pending_q, load_pending_d;
    logic [NDIG-1:0]    seg_enb_q,     seg_enb_d;
    logic [6:0]         seg_q,         seg_d;
    logic               seg_dp_q,      seg_dp_d;

    logic               scan_wrap;
    logic               frame_end;
    logic [3:0]         cur_digit;

    // BCD to {g,f,e,d,c,b,a}; non-decimal codes blank the digit
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    always_comb begin
        scan_cnt_d     = scan_cnt_q;
        idx_d          = idx_q;
        blink_cnt_d    = blink_cnt_q;
        blink_phase_d  = blink_phase_q;
        shadow_bcd_d   = shadow_bcd_q;
        shadow_dp_d    = shadow_dp_q;
        shadow_mask_d  = shadow_mask_q;
        load_pending_d = load_pending_q;

        scan_wrap = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
        frame_end = scan_wrap && (idx_q == IDX_W'(NDIG - 1));
        cur_digit = shadow_bcd_q[{idx_q, 2'b00} +: 4];

        // Digit scan
        if (scan_wrap) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IDX_W'(NDIG - 1)) ? '0 : idx_q + IDX_W'(1);
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end

        // Free-running blink timebase
        if (blink_cnt_q == BLINK_W'(BLINK_DIV - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d = blink_cnt_q + BLINK_W'(1);
        end

        // Inputs only enter at a frame boundary (or right after reset) so a frame never tears
        if (frame_end || load_pending_q) begin
            shadow_bcd_d   = i_six_bcd;
            shadow_dp_d    = i_six_dp;
            shadow_mask_d  = i_blink_mask;
            load_pending_d = 1'b0;
        end

        seg_enb_d = ~(NDIG'(1) << idx_q);
        seg_d     = seg_decode(cur_digit);
        seg_dp_d  = shadow_dp_q[idx_q];
        if (blink_phase_q && shadow_mask_q[idx_q]) begin
            seg_d    = '0;
            seg_dp_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_cnt_q     <= '0;
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            shadow_bcd_q   <= 24'hFFFFFF;
            shadow_dp_q    <= '0;
            shadow_mask_q  <= '0;
            load_pending_q <= 1'b1;
            seg_enb_q      <= 6'h3F;
            seg_q          <= '0;
            seg_dp_q       <= 1'b0;
        end else begin
            scan_cnt_q     <= scan_cnt_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            shadow_bcd_q   <= shadow_bcd_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_mask_q  <= shadow_mask_d;
            load_pending_q <= load_pending_d;
            seg_enb_q      <= seg_enb_d;
            seg_q          <= seg_d;
            seg_dp_q       <= seg_dp_d;
        end
    end

    assign o_seg_enb = seg_enb_q;
    assign o_seg     = seg_q;
    assign o_seg_dp  = seg_dp_q;

endmodule

// File: tb/tb_seg_scan.sv
// Scoreboard bench for seg_scan: a time-based reference model predicts every output
// cycle from the number of cycles since reset release and the input history.
module tb_seg_scan;

    localparam int unsigned S = 4;
    localparam int unsigned B = 32;
    localparam int unsigned F = 6 * S;

    typedef struct packed {
        logic [5:0] enb;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [23:0] i_six_bcd = '0;
    logic [5:0]  i_six_dp = '0;
    logic [5:0]  i_blink_mask = '0;
    logic [5:0]  o_seg_enb;
    logic [6:0]  o_seg;
    logic        o_seg_dp;

    out_t        exp_q[$];
    logic [35:0] hist[int];
    int          t = 0;
    int          checks = 0;
    int          errors = 0;
    bit          done = 1'b0;

    always #5 clk = ~clk;

    seg_scan #(.SCAN_DIV(S), .BLINK_DIV(B)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_six_bcd    (i_six_bcd),
        .i_six_dp     (i_six_dp),
        .i_blink_mask (i_blink_mask),
        .o_seg_enb    (o_seg_enb),
        .o_seg        (o_seg),
        .o_seg_dp     (o_seg_dp)
    );

    function automatic logic [6:0] dec(input logic [3:0] d);
        logic [6:0] tbl[16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
        return tbl[d];
    endfunction

    // t = cycles since release; displayed data is whatever was captured at the most
    // recent frame boundary (edge multiple of F) or the first edge after release.
    task automatic step(input logic r, input logic [23:0] b, input logic [5:0] d,
                        input logic [5:0] m);
        out_t        e;
        int          idx;
        int          cap;
        logic [23:0] sb;
        logic [5:0]  sd;
        logic [5:0]  sm;
        bit          ph;
        @(negedge clk);
        rst_n = r; i_six_bcd = b; i_six_dp = d; i_blink_mask = m;
        if (!r) begin
            e.enb = 6'h3F; e.seg = 7'h00; e.dp = 1'b0;
            t = 0;
            hist.delete();
        end else begin
            hist[t + 1] = {b, d, m};
            if (t == 0) begin
                sb = 24'hFFFFFF; sd = '0; sm = '0;
            end else begin
                cap = (t / F) * F;
                if (cap < 1) cap = 1;
                {sb, sd, sm} = hist[cap];
            end
            idx = (t / S) % 6;
            ph  = ((t / B) % 2) == 1;
            e.enb = ~(6'b000001 << idx);
            e.seg = dec(sb[4*idx +: 4]);
            e.dp  = sd[idx];
            if (ph && sm[idx]) begin
                e.seg = 7'h00;
                e.dp  = 1'b0;
            end
            t++;
        end
        exp_q.push_back(e);
    endtask

    // Monitor: every output cycle is compared against the oldest prediction
    initial begin
        out_t e;
        out_t a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                a = {o_seg_enb, o_seg, o_seg_dp};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs t=%0d: enb=%h seg=%h dp=%b, expected enb=%h seg=%h dp=%b",
                             t, a.enb, a.seg, a.dp, e.enb, e.seg, e.dp);
                end
            end
        end
    end

    initial begin
        logic [23:0] rb;
        logic [5:0]  rd;
        logic [5:0]  rm;
        rb = 24'h012345; rd = '0; rm = '0;

        repeat (3) step(1'b0, 24'h012345, 6'h00, 6'h00);
        repeat (2 * F + 2) step(1'b1, 24'h012345, 6'h00, 6'h00);
        repeat (2 * F) step(1'b1, 24'h012345, 6'b010100, 6'h00);

        // Mid-frame input change must not appear until the next frame
        while (((t / S) % 6) != 2) step(1'b1, 24'h012345, 6'h00, 6'h00);
        repeat (2 * F) step(1'b1, 24'h999999, 6'h00, 6'h00);

        repeat (2 * F) step(1'b1, 24'hABCDEF, 6'h3F, 6'h00);
        repeat (4 * B) step(1'b1, 24'h012345, 6'h00, 6'b000011);

        // Reset while digit 3 is being driven
        while (((t / S) % 6) != 3) step(1'b1, 24'h012345, 6'h15, 6'h00);
        step(1'b0, 24'h012345, 6'h15, 6'h00);
        repeat (2 * F) step(1'b1, 24'h012345, 6'h15, 6'h00);

        // Random inputs that change mid-frame, with occasional resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) rb = 24'($urandom);
            if ($urandom_range(0, 3) == 0) rd = 6'($urandom);
            if ($urandom_range(0, 7) == 0) rm = 6'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                for (int k = 0; k < 6; k++) rb[4*k +: 4] = 4'($urandom_range(0, 9));
            end
            step(($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1, rb, rd, rm);
        end

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard bound in case something stalls
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
